stream_pkt_gen: RTL and testbench
=================================

Name: stream_pkt_gen

Overview:
Packet transmitter that drives the slave side of the resizer (s_valid/s_last/s_keep/s_data lanes). It accepts one command (length, seed) and emits a multi-lane stream packet with incrementing data. Keep and last are generated correctly, and valid/ready backpressure is honoured. It is the traffic source for resizer bring-up and the system-level stream feeder.

Parameters:
KEEP_WIDTH, 2, number of data lanes per beat; matches resizer S_KEEP_WIDTH
T_DATA_WIDTH, 4, bits per lane
LEN_WIDTH, 8, width of packet length field, counted in lanes (elements)
CNT_WIDTH, 16, width of completed-packet counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&&ready
cmd_len_i  input  LEN_WIDTH  packet length in elements, 0 allowed
cmd_seed_i  input  T_DATA_WIDTH  value of first element
m_valid_o  output  1  stream beat valid
m_ready_i  input  1  downstream ready
m_last_o  output  1  final beat of packet
m_keep_o  output  KEEP_WIDTH  lane enables, bit k = lane k
m_data_o  output  T_DATA_WIDTH x KEEP_WIDTH (unpacked array)  lane data
busy_o  output  1  packet in progress
done_o  output  1  one-cycle pulse at packet completion
pkt_cnt_o  output  CNT_WIDTH  count of completed non-empty packets, wraps

Behaviour:
- Reset (async assert, sync release): state IDLE. m_valid_o, m_last_o, m_keep_o, all m_data_o lanes, busy_o, done_o and pkt_cnt_o are 0. cmd_ready_o is 1.
- FSM states: IDLE and SEND.
  - IDLE: cmd_ready_o=1, decoded from state.
  - SEND: cmd_ready_o=0.
- Command accept in IDLE with cmd_len_i=0: remain IDLE; done_o=1 for the next cycle; pkt_cnt_o unchanged; no beat emitted.
- Command accept in IDLE with cmd_len_i>0: register remain=cmd_len_i and next=cmd_seed_i; go to SEND. m_valid_o=1 and busy_o=1 from the following cycle, giving 1-cycle command-to-first-beat latency.
- Beat contents in SEND, all registered:
  - lane k data = (next+k) mod 2^T_DATA_WIDTH when k<remain, else 0
  - m_keep_o[k] = (k<remain); keep is contiguous from LSB
  - m_last_o = (remain<=KEEP_WIDTH)
- Handshake:
  - A beat transfers on m_valid_o&&m_ready_i.
  - While m_valid_o=1 and m_ready_i=0, every m_* output holds stable and m_valid_o must not drop.
  - m_valid_o never depends combinationally on m_ready_i.
- On a non-last transfer: remain -= KEEP_WIDTH, next += KEEP_WIDTH (mod 2^T_DATA_WIDTH). The next beat is presented in the following cycle with no bubble.
- On a last transfer:
  - m_valid_o, m_last_o and m_keep_o clear next cycle; data lanes clear to 0.
  - done_o pulses 1 cycle and pkt_cnt_o increments (wraps at 2^CNT_WIDTH).
  - busy_o clears and state returns to IDLE, so cmd_ready_o=1 next cycle.
  - Minimum gap between packets: 1 idle cycle plus 1 latency cycle.
- Commands presented in SEND are not accepted and are held by the issuer.
- Data wrap: 15→0 at T_DATA_WIDTH=4, with no carry-out.
- Reset mid-packet: asynchronous; m_valid_o drops immediately; the partial packet is discarded; pkt_cnt_o clears.
- Length arithmetic:
  - Beats per packet = ceil(len/KEEP_WIDTH).
  - remain is LEN_WIDTH bits and never underflows, because the last transfer takes the IDLE path.

Decomposition:
- Package stream_pkg:
  - typedef state_t {IDLE, SEND}
  - function keep_mask(remain) returning the contiguous LSB keep
  - localparams for lane/length widths shared with the resizer bench
- No sub-module needed. Lane data/keep generation is a generate loop inside stream_pkt_gen.

Test Plan:
1. Default params, m_ready_i=1, len=4, seed=1 → beat (1,2) keep 11 last 0, then (3,4) keep 11 last 1; done_o one pulse; pkt_cnt_o=1.
2. len=3, seed=13 → beat (13,14) keep 11 last 0, then lane0=15, lane1=0 keep 01 last 1.
3. len=5, seed=0, m_ready_i low 3 cycles during beat 2 → beat (2,3) keep 11 held stable with m_valid_o=1 throughout; then beat (4,0) keep 01 last.
4. len=0 → no m_valid_o; done_o pulse next cycle; pkt_cnt_o unchanged; cmd_ready_o stays 1.
5. len=1, seed=7, then immediate second command len=2, seed=9 → single beat 7 keep 01 last; second command waits for cmd_ready_o; then (9,10) keep 11 last; pkt_cnt_o=2.
6. rst_n low during beat 2 of len=6 → m_valid_o 0 asynchronously; after release cmd_ready_o=1, pkt_cnt_o=0.

Source files
------------

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkg
// Brief    : Shared types, default lane/length widths and keep helper for
//            the stream packet generator and resizer benches.
// Revision : 1.0
// ============================================================================
package stream_pkg;

    localparam int STREAM_KEEP_WIDTH = 2;
    localparam int STREAM_DATA_WIDTH = 4;
    localparam int STREAM_LEN_WIDTH  = 8;
    localparam int STREAM_CNT_WIDTH  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Contiguous-from-LSB keep for the remaining element count.
    function automatic logic [STREAM_KEEP_WIDTH-1:0] keep_mask(
        input logic [STREAM_LEN_WIDTH-1:0] remain
    );
        logic [STREAM_KEEP_WIDTH-1:0] mask;
        mask = '0;
        for (int k = 0; k < STREAM_KEEP_WIDTH; k++) begin
            if (int'(remain) > k) mask[k] = 1'b1;
        end
        return mask;
    endfunction

endpackage : stream_pkg
`default_nettype wire

// File: rtl/stream_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkt_gen
// Brief    : Command-driven multi-lane stream packet source with incrementing
//            data, generated keep/last and valid/ready backpressure.
// Revision : 1.0
// ============================================================================
module stream_pkt_gen
    import stream_pkg::*;
#(
    parameter int KEEP_WIDTH   = STREAM_KEEP_WIDTH,
    parameter int T_DATA_WIDTH = STREAM_DATA_WIDTH,
    parameter int LEN_WIDTH    = STREAM_LEN_WIDTH,
    parameter int CNT_WIDTH    = STREAM_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [T_DATA_WIDTH-1:0] cmd_seed_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    m_last_o,
    output logic [KEEP_WIDTH-1:0]   m_keep_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [KEEP_WIDTH],
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_WIDTH-1:0]    pkt_cnt_o
);

    localparam logic [LEN_WIDTH-1:0]    LEN_STEP  = LEN_WIDTH'(KEEP_WIDTH);
    localparam logic [T_DATA_WIDTH-1:0] DATA_STEP = T_DATA_WIDTH'(KEEP_WIDTH);

    state_t                  state;
    state_t                  state_d;
    logic [LEN_WIDTH-1:0]    remain;
    logic [LEN_WIDTH-1:0]    remain_d;
    logic [T_DATA_WIDTH-1:0] next_val;
    logic [T_DATA_WIDTH-1:0] next_val_d;
    logic                    load_beat;
    logic                    clear_beat;
    logic                    done_d;
    logic                    cnt_inc;
    logic [KEEP_WIDTH-1:0]   lane_keep;
    logic                    lane_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // The beat for the upcoming cycle is computed from the post-update
    // remain/next, so every m_* output comes straight from a flop.
    always_comb begin
        state_d    = state;
        remain_d   = remain;
        next_val_d = next_val;
        load_beat  = 1'b0;
        clear_beat = 1'b0;
        done_d     = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = SEND;
                        remain_d   = cmd_len_i;
                        next_val_d = cmd_seed_i;
                        load_beat  = 1'b1;
                    end
                end
            end
            SEND: begin
                if (m_ready_i) begin
                    if (m_last_o) begin
                        state_d    = IDLE;
                        clear_beat = 1'b1;
                        done_d     = 1'b1;
                        cnt_inc    = 1'b1;
                    end else begin
                        remain_d   = remain - LEN_STEP;
                        next_val_d = next_val + DATA_STEP;
                        load_beat  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lane_last   = (remain_d <= LEN_STEP);
    assign cmd_ready_o = (state == IDLE);
    assign m_valid_o   = (state == SEND);
    assign busy_o      = (state == SEND);

    generate
        for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_lane
            localparam logic [LEN_WIDTH-1:0]    LANE_IDX = LEN_WIDTH'(k);
            localparam logic [T_DATA_WIDTH-1:0] LANE_OFS = T_DATA_WIDTH'(k);
            logic [T_DATA_WIDTH-1:0] lane_data_q;

            assign lane_keep[k] = (LANE_IDX < remain_d);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_data_q <= '0;
                end else if (load_beat) begin
                    lane_data_q <= lane_keep[k] ? (next_val_d + LANE_OFS) : '0;
                end else if (clear_beat) begin
                    lane_data_q <= '0;
                end
            end

            assign m_data_o[k] = lane_data_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain    <= '0;
            next_val  <= '0;
            m_last_o  <= 1'b0;
            m_keep_o  <= '0;
            done_o    <= 1'b0;
            pkt_cnt_o <= '0;
        end else begin
            remain   <= remain_d;
            next_val <= next_val_d;
            done_o   <= done_d;
            if (cnt_inc) pkt_cnt_o <= pkt_cnt_o + 1'b1;
            if (load_beat) begin
                m_last_o <= lane_last;
                m_keep_o <= lane_keep;
            end else if (clear_beat) begin
                m_last_o <= 1'b0;
                m_keep_o <= '0;
            end
        end
    end

endmodule : stream_pkt_gen
`default_nettype wire

// File: tb/tb_stream_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_pkt_gen
// Brief    : Directed self-checking bench for stream_pkt_gen (default params).
// Revision : 1.0
// ============================================================================
module tb_stream_pkt_gen;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic [3:0] cmd_seed;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic [1:0] m_keep;
    logic [3:0] m_data [2];
    logic       busy;
    logic       done;
    logic [15:0] pkt_cnt;

    int checks = 0;
    int passed = 0;

    stream_pkt_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_len_i  (cmd_len),
        .cmd_seed_i (cmd_seed),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .m_last_o   (m_last),
        .m_keep_o   (m_keep),
        .m_data_o   (m_data),
        .busy_o     (busy),
        .done_o     (done),
        .pkt_cnt_o  (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, last, keep[1:0], lane1, lane0}
    function automatic logic [11:0] beat_vec();
        return {m_valid, m_last, m_keep, m_data[1], m_data[0]};
    endfunction

    // {cmd_ready, busy, done, pkt_cnt}
    function automatic logic [18:0] ctl_vec();
        return {cmd_ready, busy, done, pkt_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_seed = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++; if (beat_vec() !== 12'h000) $display("FAIL reset_beat: got %h want 000", beat_vec()); else passed++;
        checks++; if (ctl_vec() !== {3'b100, 16'd0}) $display("FAIL reset_ctl: got %h want %h", ctl_vec(), {3'b100, 16'd0}); else passed++;
    endtask

    task automatic test_basic();
        cmd_valid = 1'b1; cmd_len = 8'd4; cmd_seed = 4'd1;
        step();
        cmd_valid = 1'b0;
        checks++; if (beat_vec() !== 12'hB21) $display("FAIL basic_beat1: got %h want B21", beat_vec()); else passed++;
        checks++; if (ctl_vec() !== {3'b010, 16'd0}) $display("FAIL basic_busy: got %h want %h", ctl_vec(), {3'b010, 16'd0}); else passed++;
        step();
        checks++; if (beat_vec() !== 12'hF43) $display("FAIL basic_beat2: got %h want F43", beat_vec()); else passed++;
        step();
        checks++; if (beat_vec() !== 12'h000) $display("FAIL basic_end_beat: got %h want 000", beat_vec()); else passed++;
        checks++; if (ctl_vec() !== {3'b101, 16'd1}) $display("FAIL basic_done: got %h want %h", ctl_vec(), {3'b101, 16'd1}); else passed++;
        step();
        checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else passed++;
    endtask

    task automatic test_wrap();
        cmd_valid = 1'b1; cmd_len = 8'd3; cmd_seed = 4'd13;
        step();
        cmd_valid = 1'b0;
        checks++; if (beat_vec() !== 12'hBED) $display("FAIL wrap_beat1: got %h want BED", beat_vec()); else passed++;
        step();
        checks++; if (beat_vec() !== 12'hD0F) $display("FAIL wrap_beat2: got %h want D0F", beat_vec()); else passed++;
        step();
        checks++; if (ctl_vec() !== {3'b101, 16'd2}) $display("FAIL wrap_done: got %h want %h", ctl_vec(), {3'b101, 16'd2}); else passed++;
        step();
    endtask

    task automatic test_backpressure();
        cmd_valid = 1'b1; cmd_len = 8'd5; cmd_seed = 4'd0;
        step();
        cmd_valid = 1'b0;
        checks++; if (beat_vec() !== 12'hB10) $display("FAIL bp_beat1: got %h want B10", beat_vec()); else passed++;
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (beat_vec() !== 12'hB32) $display("FAIL bp_hold%0d: got %h want B32", i, beat_vec()); else passed++;
            step();
        end
        checks++; if (beat_vec() !== 12'hB32) $display("FAIL bp_hold_end: got %h want B32", beat_vec()); else passed++;
        m_ready = 1'b1;
        step();
        checks++; if (beat_vec() !== 12'hD04) $display("FAIL bp_beat3: got %h want D04", beat_vec()); else passed++;
        step();
        checks++; if (ctl_vec() !== {3'b101, 16'd3}) $display("FAIL bp_done: got %h want %h", ctl_vec(), {3'b101, 16'd3}); else passed++;
        step();
    endtask

    task automatic test_zero_len();
        cmd_valid = 1'b1; cmd_len = 8'd0; cmd_seed = 4'd5;
        step();
        cmd_valid = 1'b0;
        checks++; if (beat_vec() !== 12'h000) $display("FAIL zero_beat: got %h want 000", beat_vec()); else passed++;
        checks++; if (ctl_vec() !== {3'b101, 16'd3}) $display("FAIL zero_done: got %h want %h", ctl_vec(), {3'b101, 16'd3}); else passed++;
        step();
        checks++; if (ctl_vec() !== {3'b100, 16'd3}) $display("FAIL zero_after: got %h want %h", ctl_vec(), {3'b100, 16'd3}); else passed++;
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_len = 8'd1; cmd_seed = 4'd7;
        step();
        cmd_len = 8'd2; cmd_seed = 4'd9;
        checks++; if (beat_vec() !== 12'hD07) $display("FAIL b2b_single: got %h want D07", beat_vec()); else passed++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_not_ready: got %b want 0", cmd_ready); else passed++;
        step();
        checks++; if (ctl_vec() !== {3'b101, 16'd4}) $display("FAIL b2b_first_done: got %h want %h", ctl_vec(), {3'b101, 16'd4}); else passed++;
        checks++; if (m_valid !== 1'b0) $display("FAIL b2b_gap: got %b want 0", m_valid); else passed++;
        step();
        cmd_valid = 1'b0;
        checks++; if (beat_vec() !== 12'hFA9) $display("FAIL b2b_second: got %h want FA9", beat_vec()); else passed++;
        step();
        checks++; if (ctl_vec() !== {3'b101, 16'd5}) $display("FAIL b2b_second_done: got %h want %h", ctl_vec(), {3'b101, 16'd5}); else passed++;
        step();
    endtask

    task automatic test_reset_mid_packet();
        cmd_valid = 1'b1; cmd_len = 8'd6; cmd_seed = 4'd0;
        step();
        cmd_valid = 1'b0;
        step();
        checks++; if (beat_vec() !== 12'hB32) $display("FAIL rst_mid_beat2: got %h want B32", beat_vec()); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (beat_vec() !== 12'h000) $display("FAIL rst_mid_async: got %h want 000", beat_vec()); else passed++;
        checks++; if (ctl_vec() !== {3'b100, 16'd0}) $display("FAIL rst_mid_ctl: got %h want %h", ctl_vec(), {3'b100, 16'd0}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++; if (ctl_vec() !== {3'b100, 16'd0}) $display("FAIL rst_mid_release: got %h want %h", ctl_vec(), {3'b100, 16'd0}); else passed++;
        checks++; if (m_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", m_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_stream_pkt_gen
`default_nettype wire
